// File: rtl/axi4s_frame_checker.sv
// Passive AXI4-Stream video monitor: measures active width/height of every frame,
// compares them with the expected geometry latched at SOF and reports one result per frame.
module axi4s_frame_checker #(
    parameter int DATA_WIDTH = 24,
    parameter int PPC        = 1,
    parameter int W_BITS     = 13,
    parameter int H_BITS     = 12
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [W_BITS-1:0]     exp_width,
    input  logic [H_BITS-1:0]     exp_height,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  frame_done,
    output logic [W_BITS-1:0]     meas_width,
    output logic [H_BITS-1:0]     meas_height,
    output logic                  width_err,
    output logic                  height_err,
    output logic                  sof_err,
    output logic [15:0]           frame_count,
    output logic [15:0]           pass_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        WAIT_SOF = 2'd2
    } state_t;

    localparam logic [W_BITS-1:0] W_MAX  = {W_BITS{1'b1}};
    localparam logic [W_BITS-1:0] W_ZERO = {W_BITS{1'b0}};
    localparam logic [H_BITS-1:0] H_MAX  = {H_BITS{1'b1}};
    localparam logic [H_BITS-1:0] H_ZERO = {H_BITS{1'b0}};
    localparam logic [H_BITS-1:0] H_ONE  = H_BITS'(1);
    localparam logic [W_BITS-1:0] PPC_W  = W_BITS'(PPC);

    state_t            state_r;
    logic [W_BITS-1:0] pix_cnt_r;
    logic              pix_sat_r;
    logic [H_BITS-1:0] line_cnt_r;
    logic [W_BITS-1:0] last_w_r;
    logic [W_BITS-1:0] exp_w_r;
    logic [H_BITS-1:0] exp_h_r;
    logic              werr_r;
    logic              serr_r;

    logic              beat_s;
    logic [W_BITS:0]   sum_s;
    logic              line_ovf_s;
    logic [W_BITS-1:0] line_w_s;
    logic              line_bad_s;
    logic [H_BITS-1:0] lines_next_s;
    logic [W_BITS-1:0] sf_pix_s;
    logic [H_BITS-1:0] sf_lines_s;
    logic [W_BITS-1:0] sf_last_w_s;
    logic              sf_werr_s;
    logic              sf_close_s;
    logic              do_close_s;
    logic [W_BITS-1:0] c_width_s;
    logic [H_BITS-1:0] c_height_s;
    logic              c_werr_s;
    logic              c_herr_s;
    logic              c_serr_s;
    logic              unused_data_s;

    assign unused_data_s = ^s_axis_tdata;
    assign beat_s        = s_axis_tvalid & s_axis_tready;

    // Saturating line arithmetic plus the counter values a fresh frame starts from
    always_comb begin
        sum_s        = {1'b0, pix_cnt_r} + {1'b0, PPC_W};
        line_ovf_s   = sum_s[W_BITS] | pix_sat_r;
        line_w_s     = line_ovf_s ? W_MAX : sum_s[W_BITS-1:0];
        line_bad_s   = line_ovf_s | (line_w_s != exp_w_r);
        lines_next_s = (line_cnt_r == H_MAX) ? H_MAX : (line_cnt_r + H_ONE);
        sf_pix_s     = s_axis_tlast ? W_ZERO : PPC_W;
        sf_lines_s   = s_axis_tlast ? H_ONE : H_ZERO;
        sf_last_w_s  = s_axis_tlast ? PPC_W : W_ZERO;
        sf_werr_s    = s_axis_tlast & (PPC_W != exp_width);
        sf_close_s   = s_axis_tlast & (exp_height == H_ONE);
    end

    // Decide whether this beat closes a frame and what that frame reports
    always_comb begin
        do_close_s = 1'b0;
        c_width_s  = last_w_r;
        c_height_s = line_cnt_r;
        c_werr_s   = werr_r;
        c_herr_s   = 1'b0;
        c_serr_s   = serr_r;
        if (enable && beat_s) begin
            if (state_r == ACTIVE) begin
                if (s_axis_tuser) begin
                    do_close_s = 1'b1;
                    c_herr_s   = 1'b1;
                    c_serr_s   = serr_r | (pix_cnt_r != W_ZERO);
                end else if (s_axis_tlast && (lines_next_s == exp_h_r)) begin
                    do_close_s = 1'b1;
                    c_width_s  = line_w_s;
                    c_height_s = lines_next_s;
                    c_werr_s   = werr_r | line_bad_s;
                end else begin
                    do_close_s = 1'b0;
                end
            end else if (s_axis_tuser && sf_close_s) begin
                do_close_s = 1'b1;
                c_width_s  = PPC_W;
                c_height_s = H_ONE;
                c_werr_s   = sf_werr_s;
            end else begin
                do_close_s = 1'b0;
            end
        end else begin
            do_close_s = 1'b0;
        end
    end

    // Frame tracking state machine with registered result outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= IDLE;
            pix_cnt_r   <= W_ZERO;
            pix_sat_r   <= 1'b0;
            line_cnt_r  <= H_ZERO;
            last_w_r    <= W_ZERO;
            exp_w_r     <= W_ZERO;
            exp_h_r     <= H_ZERO;
            werr_r      <= 1'b0;
            serr_r      <= 1'b0;
            frame_done  <= 1'b0;
            meas_width  <= W_ZERO;
            meas_height <= H_ZERO;
            width_err   <= 1'b0;
            height_err  <= 1'b0;
            sof_err     <= 1'b0;
            frame_count <= 16'd0;
            pass_count  <= 16'd0;
        end else begin
            frame_done <= do_close_s;
            if (do_close_s) begin
                meas_width  <= c_width_s;
                meas_height <= c_height_s;
                width_err   <= c_werr_s;
                height_err  <= c_herr_s;
                sof_err     <= c_serr_s;
                frame_count <= frame_count + 16'd1;
                if (!(c_werr_s || c_herr_s || c_serr_s)) begin
                    pass_count <= pass_count + 16'd1;
                end else begin
                    pass_count <= pass_count;
                end
            end else begin
                meas_width <= meas_width;
            end

            if (!enable) begin
                state_r    <= IDLE;
                pix_cnt_r  <= W_ZERO;
                pix_sat_r  <= 1'b0;
                line_cnt_r <= H_ZERO;
                last_w_r   <= W_ZERO;
                werr_r     <= 1'b0;
                serr_r     <= 1'b0;
            end else if (beat_s) begin
                if (s_axis_tuser) begin
                    // Any SOF (first, after a close, or early) restarts the counters with this beat
                    exp_w_r    <= exp_width;
                    exp_h_r    <= exp_height;
                    pix_cnt_r  <= sf_pix_s;
                    pix_sat_r  <= 1'b0;
                    line_cnt_r <= sf_lines_s;
                    last_w_r   <= sf_last_w_s;
                    werr_r     <= sf_close_s ? 1'b0 : sf_werr_s;
                    serr_r     <= (do_close_s || state_r == ACTIVE) ? 1'b0 : serr_r;
                    state_r    <= sf_close_s ? WAIT_SOF : ACTIVE;
                end else begin
                    case (state_r)
                        ACTIVE: begin
                            if (s_axis_tlast) begin
                                last_w_r   <= line_w_s;
                                pix_cnt_r  <= W_ZERO;
                                pix_sat_r  <= 1'b0;
                                line_cnt_r <= lines_next_s;
                                if (do_close_s) begin
                                    werr_r  <= 1'b0;
                                    serr_r  <= 1'b0;
                                    state_r <= WAIT_SOF;
                                end else begin
                                    werr_r  <= werr_r | line_bad_s;
                                end
                            end else begin
                                pix_cnt_r <= line_w_s;
                                pix_sat_r <= line_ovf_s;
                            end
                        end
                        WAIT_SOF: serr_r  <= 1'b1;
                        IDLE:     state_r <= IDLE;
                        default:  state_r <= IDLE;
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_axi4s_frame_checker.sv
// Directed bench for axi4s_frame_checker: a frame-level reference model built from
// per-line width lists is compared with the DUT every cycle, plus literal spot checks.
module tb_axi4s_frame_checker;

    localparam int PPC    = 2;
    localparam int W_BITS = 13;
    localparam int H_BITS = 12;
    localparam int WMAX   = 8191;
    localparam int HMAX   = 4095;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              enable = 1'b0;
    logic [W_BITS-1:0] exp_width = 13'd8;
    logic [H_BITS-1:0] exp_height = 12'd4;
    logic [23:0]       s_axis_tdata = 24'd0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready = 1'b1;
    logic              s_axis_tuser = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              frame_done;
    logic [W_BITS-1:0] meas_width;
    logic [H_BITS-1:0] meas_height;
    logic              width_err;
    logic              height_err;
    logic              sof_err;
    logic [15:0]       frame_count;
    logic [15:0]       pass_count;

    int n_chk  = 0;
    int n_fail = 0;
    int stall_pct = 0;

    axi4s_frame_checker #(
        .DATA_WIDTH(24), .PPC(PPC), .W_BITS(W_BITS), .H_BITS(H_BITS)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .exp_width(exp_width), .exp_height(exp_height),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .frame_done(frame_done),
        .meas_width(meas_width), .meas_height(meas_height),
        .width_err(width_err), .height_err(height_err), .sof_err(sof_err),
        .frame_count(frame_count), .pass_count(pass_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of line widths in pixels
    int   widths[$];
    int   m_pix, m_ew, m_eh, m_fc, m_pc;
    bit   m_in_frame, m_waiting, m_stray;
    logic m_done, m_we, m_he, m_se;
    logic [W_BITS-1:0] m_mw;
    logic [H_BITS-1:0] m_mh;

    task automatic m_report(input bit early, input bit midline);
        bit we;
        int last;
        we = 1'b0;
        foreach (widths[i]) if (widths[i] != m_ew) we = 1'b1;
        last   = (widths.size() == 0) ? 0 : widths[widths.size()-1];
        m_done = 1'b1;
        m_mw   = W_BITS'((last > WMAX) ? WMAX : last);
        m_mh   = H_BITS'((widths.size() > HMAX) ? HMAX : widths.size());
        m_we   = we;
        m_he   = early || (widths.size() != m_eh);
        m_se   = m_stray || midline;
        m_stray = 1'b0;
        m_fc   = (m_fc + 1) % 65536;
        if (!(m_we || m_he || m_se)) m_pc = (m_pc + 1) % 65536;
    endtask

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            widths.delete();
            m_pix = 0; m_ew = 0; m_eh = 0; m_fc = 0; m_pc = 0;
            m_in_frame = 1'b0; m_waiting = 1'b0; m_stray = 1'b0;
            m_done = 1'b0; m_we = 1'b0; m_he = 1'b0; m_se = 1'b0;
            m_mw = '0; m_mh = '0;
        end else begin
            m_done = 1'b0;
            if (!enable) begin
                widths.delete();
                m_pix = 0; m_in_frame = 1'b0; m_waiting = 1'b0; m_stray = 1'b0;
            end else if (s_axis_tvalid && s_axis_tready) begin
                if (s_axis_tuser) begin
                    if (m_in_frame) m_report(1'b1, m_pix != 0);
                    widths.delete();
                    m_pix = 0; m_in_frame = 1'b1; m_waiting = 1'b0;
                    m_ew = int'(exp_width); m_eh = int'(exp_height);
                end else if (m_waiting) begin
                    m_stray = 1'b1;
                end
                if (m_in_frame) begin
                    m_pix += PPC;
                    if (s_axis_tlast) begin
                        widths.push_back(m_pix);
                        m_pix = 0;
                        if (widths.size() == m_eh) begin
                            m_report(1'b0, 1'b0);
                            m_in_frame = 1'b0;
                            m_waiting  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge aclk) begin
        if (aresetn) begin
            chk("frame_done", frame_done, m_done);
            chk("frame_count", frame_count, m_fc);
            chk("pass_count", pass_count, m_pc);
            chk("meas_width", meas_width, m_mw);
            chk("meas_height", meas_height, m_mh);
            chk("width_err", width_err, m_we);
            chk("height_err", height_err, m_he);
            chk("sof_err", sof_err, m_se);
        end
    end

    task automatic beat(input logic u, input logic l);
        logic r;
        int tries;
        tries = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tdata  = 24'($urandom);
        do begin
            r = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            s_axis_tready = r;
            @(posedge aclk); #2;
            tries++;
        end while (!r && tries < 1000);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tready = 1'b1;
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic send_line(input int beats, input bit sof);
        for (int i = 0; i < beats; i++) beat(sof && i == 0, i == beats - 1);
    endtask

    task automatic send_frame(input int lines, input int bpl);
        for (int l = 0; l < lines; l++) send_line(bpl, l == 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        enable  = 1'b1;
        idle(2);

        // 1: clean 8x4 frame
        exp_width = 13'd8; exp_height = 12'd4;
        send_frame(4, 4);
        idle(2);
        chk("t1_width", meas_width, 8);
        chk("t1_height", meas_height, 4);
        chk("t1_errs", {width_err, height_err, sof_err}, 0);
        chk("t1_fc", frame_count, 1);
        chk("t1_pc", pass_count, 1);

        // 2: three back-to-back 800x6 frames under random back-pressure
        exp_width = 13'd800; exp_height = 12'd6;
        stall_pct = 30;
        for (int f = 0; f < 3; f++) send_frame(6, 400);
        stall_pct = 0;
        idle(2);
        chk("t2_width", meas_width, 800);
        chk("t2_height", meas_height, 6);
        chk("t2_pc", pass_count, 4);

        // 3: line 2 one beat short
        exp_width = 13'd8; exp_height = 12'd4;
        send_line(4, 1'b1); send_line(3, 1'b0); send_line(4, 1'b0); send_line(4, 1'b0);
        idle(2);
        chk("t3_werr", width_err, 1);
        chk("t3_height", meas_height, 4);
        chk("t3_pc", pass_count, 4);

        // 4: early SOF after two full lines, then a clean frame
        send_frame(2, 4);
        beat(1'b1, 1'b0);
        chk("t4_done", frame_done, 1);
        chk("t4_height", meas_height, 2);
        chk("t4_herr", height_err, 1);
        chk("t4_serr", sof_err, 0);
        send_line(3, 1'b0);
        for (int l = 0; l < 3; l++) send_line(4, 1'b0);
        idle(2);
        chk("t4_fc", frame_count, 7);
        chk("t4_pc", pass_count, 5);

        // 5: stray beats while waiting for SOF, then mid-line SOF
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0);
        idle(1);
        send_frame(4, 4);
        idle(2);
        chk("t5_stray_serr", sof_err, 1);
        chk("t5_stray_pc", pass_count, 5);
        beat(1'b1, 1'b0); beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        chk("t5_mid_serr", sof_err, 1);
        chk("t5_mid_herr", height_err, 1);
        send_line(3, 1'b0);
        for (int l = 0; l < 3; l++) send_line(4, 1'b0);
        idle(2);
        chk("t5_pc", pass_count, 6);

        // one-beat frames closing on consecutive cycles
        exp_width = 13'd2; exp_height = 12'd1;
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b1);
        idle(2);
        chk("t5b_fc", frame_count, 12);
        chk("t5b_pc", pass_count, 8);

        // over-long line saturates the width
        exp_width = 13'd8; exp_height = 12'd1;
        send_line(4100, 1'b1);
        idle(2);
        chk("sat_width", meas_width, WMAX);
        chk("sat_werr", width_err, 1);

        // 6: asynchronous reset mid-frame
        exp_height = 12'd4;
        send_line(4, 1'b1); beat(1'b0, 1'b0);
        #1 aresetn = 1'b0;
        #1;
        chk("rst_fc", frame_count, 0);
        chk("rst_outs", {frame_done, meas_width, meas_height, width_err, height_err, sof_err, pass_count}, 0);
        @(posedge aclk); #2;
        aresetn = 1'b1;
        idle(2);
        send_frame(4, 4);
        idle(2);
        chk("rst_new_fc", frame_count, 1);
        chk("rst_new_pc", pass_count, 1);

        // enable dropped mid-frame
        send_line(4, 1'b1); send_line(4, 1'b0);
        idle(0);
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        send_line(4, 1'b0); send_line(4, 1'b0);
        idle(3);
        chk("en_fc", frame_count, 1);
        chk("en_pc", pass_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4s_frame_checker.md
# axi4s_frame_checker

- Synthesizable, passive AXI4-Stream video monitor. Sits on any video stream in the block design, for example at the TPG output ahead of the AXI4-Stream-to-video-out bridge.
- Per frame, it measures the active width (pixels per line) and height (lines per frame), compares them against the expected values, and reports one result per frame.
- It replaces ad-hoc bench-side pixel counting with a reusable, parametrised checker that handles multiple pixels per clock.
- Error flags can be read back over AXI4-Lite by a wrapper.

## Interface

Parameters:
- DATA_WIDTH, 24, tdata width. Informational only; data is not inspected.
- PPC, 1, pixels per clock (1, 2 or 4). Each accepted beat carries PPC pixels.
- W_BITS, 13, width of the pixel and width counters.
- H_BITS, 12, width of the line counter.

Ports:
- aclk  in  1  stream clock. One clock domain only.
- aresetn  in  1  asynchronous, active-low reset.
- enable  in  1  checker enable, sampled every cycle.
- exp_width  in  W_BITS  expected pixels per line. Must be a multiple of PPC and nonzero.
- exp_height  in  H_BITS  expected lines per frame. Must be nonzero.
- s_axis_tdata  in  DATA_WIDTH  monitored data, ignored.
- s_axis_tvalid  in  1  monitored valid.
- s_axis_tready  in  1  monitored ready. The block is passive and never drives it.
- s_axis_tuser  in  1  start of frame (SOF).
- s_axis_tlast  in  1  end of line (EOL).
- frame_done  out  1  one-cycle pulse when a frame closes. The result outputs are valid from that cycle onward.
- meas_width  out  W_BITS  width of the last completed line of the closed frame.
- meas_height  out  H_BITS  lines completed in the closed frame.
- width_err  out  1  at least one line width differed from exp_width.
- height_err  out  1  meas_height differed from exp_height.
- sof_err  out  1  beats were received outside a frame, or SOF arrived mid-line.
- frame_count  out  16  frames closed since reset. Wraps.
- pass_count  out  16  frames closed with no error. Wraps.

## Operation

- A beat is accepted when tvalid && tready. Only accepted beats affect state.
- Expected values are latched at SOF. Changes to exp_width or exp_height mid-frame take effect from the next frame.

State machine:
- IDLE: the default after reset and whenever enable = 0. Moves to ACTIVE on an accepted beat with tuser = 1 while enable = 1.
- ACTIVE:
  - Each accepted beat adds PPC to pix_cnt. The SOF beat counts as the first beat.
  - On a tlast beat: line_w = pix_cnt + PPC. If line_w ≠ exp_width, set the per-frame width_err. Record line_w, clear pix_cnt, and increment line_cnt.
  - If that tlast completes line exp_height, close the frame and move to WAIT_SOF.
- ACTIVE, tuser beat arriving before the frame has closed (early SOF):
  - Close the current frame with height_err = 1.
  - If pix_cnt ≠ 0, also set sof_err.
  - The same beat then starts a new frame: counters restart with this beat counted, and the state stays ACTIVE.
- WAIT_SOF:
  - An accepted beat with tuser = 0 is a stray beat. It sets a pending sof_err, which is reported in the next closed frame.
  - A tuser beat moves to ACTIVE.
- A beat with both tuser and tlast is a 1-beat line: line_w = PPC.

Closing a frame:
- Register the result outputs and pulse frame_done.
- Increment frame_count.
- Increment pass_count only if no error flag is set.
- Clear the per-frame error flags internally after reporting them. The output flags hold their values until the next close.

Enable:
- Deasserting enable goes to IDLE on the next edge and discards the partial frame. No frame_done is produced, and outputs and counts are unchanged.

Arithmetic:
- pix_cnt and line_w saturate at 2^W_BITS−1.
- line_cnt saturates at 2^H_BITS−1.
- A saturated width never compares equal to exp_width, so width_err is set.

## Timing

- frame_done is asserted on the clock edge after the accepted closing beat, so latency is 1 cycle.
- Result outputs update on the same edge as the frame_done pulse.
- Two frames cannot close on consecutive cycles unless each frame is one beat. That case must still produce two pulses.
- After reset:
  - Reset is asynchronous and takes effect immediately.
  - All outputs are 0.
  - The state is IDLE and all internal counters are cleared.
- If reset is asserted mid-frame, the partial frame is lost and the first frame_done after reset comes from a complete new frame.
- tvalid without tready is ignored, including during back-pressure stalls of any length.

## Test plan

1. PPC = 1, exp 8×4, one clean frame:
   - 4 lines of 8 beats, SOF on beat 0.
   - Expect: frame_done 1 cycle after the 32nd beat, meas_width = 8, meas_height = 4, all errors 0, frame_count = 1, pass_count = 1.
2. PPC = 2, exp 800×600, continuous frames with random tready stalls:
   - Each line is 400 beats.
   - Expect: three frame_done pulses, each with meas 800/600, no errors, pass_count = 3.
3. Width error:
   - Line 2 of an 8×4 frame is 7 beats.
   - Expect: width_err = 1, meas_height = 4, pass_count unchanged.
4. Early SOF:
   - SOF arrives after 2 full lines of an 8×4 frame.
   - Expect: frame_done with meas_height = 2, height_err = 1, sof_err = 0.
   - The next complete frame then passes.
5. Stray beats and mid-line SOF:
   - 3 beats with no SOF in WAIT_SOF, followed by a clean frame.
   - Expect: that frame reports sof_err = 1.
   - Separately, an SOF at pix_cnt = 3 sets both sof_err and height_err.
6. Reset and enable:
   - aresetn is pulsed low mid-frame: all outputs go to 0 immediately, and a new clean frame passes with frame_count = 1.
   - enable is dropped mid-frame: no frame_done is produced and counts are unchanged.
